// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared control encodings for the pipeline hazard logic.
package cpu_ctrl_pkg;
   typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH} state_t;
   localparam logic [1:0] BR_BEQ = 2'b01;
   localparam logic [1:0] BR_BNE = 2'b10;
   localparam int WAIT_MAX_DEF = 15;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags an ID-stage read of a register still being loaded in EX.
module load_use_detect (
   input  logic       ex_MemtoReg,
   input  logic       ex_RegWr,
   input  logic [4:0] ex_regAddr,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_uses_rt,
   output logic       load_use
);
   always_comb
      load_use = ex_MemtoReg & ex_RegWr & (ex_regAddr != 5'd0) &
                 ((ex_regAddr == id_rs) | (id_uses_rt & (ex_regAddr == id_rt)));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush control for memory waits, taken branches and load-use hazards.
module pipe_hazard_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int WAIT_MAX = WAIT_MAX_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_uses_rt,
   input  logic        ex_MemtoReg,
   input  logic        ex_RegWr,
   input  logic [4:0]  ex_regAddr,
   input  logic [1:0]  mem_Br,
   input  logic        mem_zero,
   input  logic        mem_MemWr,
   input  logic        mem_MemtoReg,
   input  logic        dmem_ready,
   output logic        pc_we,
   output logic        ifid_we,
   output logic        idex_we,
   output logic        exmem_we,
   output logic        pc_sel,
   output logic        ifid_flush,
   output logic        idex_flush,
   output logic        exmem_flush,
   output logic        timeout_err,
   output logic [15:0] stall_cnt
);
   localparam int CW = $clog2(WAIT_MAX + 1);

   state_t state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic load_use, mem_busy, br_taken, timed_out, hold, lu_eff, run;

   load_use_detect u_lud (
      .ex_MemtoReg(ex_MemtoReg),
      .ex_RegWr(ex_RegWr),
      .ex_regAddr(ex_regAddr),
      .id_rs(id_rs),
      .id_rt(id_rt),
      .id_uses_rt(id_uses_rt),
      .load_use(load_use)
   );

   always_comb begin
      mem_busy = (mem_MemWr | mem_MemtoReg) & ~dmem_ready;
      br_taken = ((mem_Br == BR_BEQ) & mem_zero) | ((mem_Br == BR_BNE) & ~mem_zero);
      timed_out = (state == MEM_WAIT) & ~dmem_ready & (cnt == CW'(WAIT_MAX));
      // a timeout releases the wait exactly as a ready would
      hold = (state == MEM_WAIT) ? ~dmem_ready & ~timed_out : mem_busy;
      lu_eff = load_use & (state != FLUSH);
      state_nx = hold ? MEM_WAIT : br_taken ? FLUSH : RUN;
      cnt_nx = !hold ? '0 : (state == MEM_WAIT) ? cnt + 1'b1 : CW'(1);
      run = rst_n & ~hold;
      pc_we = run & (br_taken | ~lu_eff);
      ifid_we = run & (br_taken | ~lu_eff);
      idex_we = run;
      exmem_we = run;
      pc_sel = run & br_taken;
      ifid_flush = run & br_taken;
      idex_flush = run & (br_taken | lu_eff);
      exmem_flush = run & br_taken;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= RUN;
         cnt <= '0;
         timeout_err <= 1'b0;
         stall_cnt <= '0;
      end else begin
         state <= state_nx;
         cnt <= cnt_nx;
         if (timed_out) timeout_err <= 1'b1;
         if (!pc_we && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and random stimulus scored against a cycle-level reference model.
module tb_pipe_hazard_ctrl;
   localparam int WAIT_MAX = 15;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [4:0] id_rs = '0, id_rt = '0, ex_regAddr = '0;
   logic id_uses_rt = 1'b0, ex_MemtoReg = 1'b0, ex_RegWr = 1'b0;
   logic [1:0] mem_Br = '0;
   logic mem_zero = 1'b0, mem_MemWr = 1'b0, mem_MemtoReg = 1'b0, dmem_ready = 1'b1;
   logic pc_we, ifid_we, idex_we, exmem_we, pc_sel, ifid_flush, idex_flush, exmem_flush, timeout_err;
   logic [15:0] stall_cnt;

   int n_cmp = 0, n_bad = 0;
   logic [24:0] exp_q[$];

   // reference state: are we waiting on memory, for how long, and is ID holding a flush bubble
   bit m_wait, m_bub, m_to;
   int m_waited, m_sc;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.WAIT_MAX(WAIT_MAX)) dut (
      .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .ex_MemtoReg(ex_MemtoReg), .ex_RegWr(ex_RegWr), .ex_regAddr(ex_regAddr),
      .mem_Br(mem_Br), .mem_zero(mem_zero), .mem_MemWr(mem_MemWr), .mem_MemtoReg(mem_MemtoReg),
      .dmem_ready(dmem_ready), .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we),
      .exmem_we(exmem_we), .pc_sel(pc_sel), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
      .exmem_flush(exmem_flush), .timeout_err(timeout_err), .stall_cnt(stall_cnt)
   );

   task automatic predict();
      logic [24:0] e;
      bit busy, brt, lu, tmo, hold, stall_lu;
      if (!rst_n) begin
         m_wait = 0; m_waited = 0; m_bub = 0; m_to = 0; m_sc = 0;
         e = '0;
      end else begin
         busy = (mem_MemWr || mem_MemtoReg) && !dmem_ready;
         brt = (mem_Br == 2'd1 && mem_zero) || (mem_Br == 2'd2 && !mem_zero);
         lu = ex_MemtoReg && ex_RegWr && ex_regAddr != 0 &&
              (ex_regAddr == id_rs || (id_uses_rt && ex_regAddr == id_rt));
         tmo = m_wait && !dmem_ready && m_waited == WAIT_MAX;
         hold = m_wait ? (!dmem_ready && !tmo) : busy;
         stall_lu = lu && !m_bub;
         if (hold) e[24:16] = 9'b0000_0_000_0;
         else if (brt) e[24:16] = 9'b1111_1_111_0;
         else if (stall_lu) e[24:16] = 9'b0011_0_010_0;
         else e[24:16] = 9'b1111_0_000_0;
         e[16] = m_to;
         e[15:0] = 16'(m_sc);
         if (!e[24] && m_sc < 65535) m_sc++;
         if (tmo) m_to = 1;
         if (hold) begin
            m_waited = m_wait ? m_waited + 1 : 1;
            m_wait = 1;
            m_bub = 0;
         end else begin
            m_wait = 0;
            m_waited = 0;
            m_bub = brt;
         end
      end
      exp_q.push_back(e);
   endtask

   task automatic cyc(input logic r, input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                      input logic emtr, input logic erw, input logic [4:0] era,
                      input logic [1:0] br, input logic z, input logic mw, input logic mtr,
                      input logic rdy);
      @(posedge clk);
      #1;
      rst_n = r; id_rs = rs; id_rt = rt; id_uses_rt = urt;
      ex_MemtoReg = emtr; ex_RegWr = erw; ex_regAddr = era;
      mem_Br = br; mem_zero = z; mem_MemWr = mw; mem_MemtoReg = mtr; dmem_ready = rdy;
      #1;
      predict();
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1);
   endtask

   always @(negedge clk) begin
      logic [24:0] got, e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         got = {pc_we, ifid_we, idex_we, exmem_we, pc_sel, ifid_flush, idex_flush, exmem_flush,
                timeout_err, stall_cnt};
         n_cmp++;
         if (got !== e) begin
            n_bad++;
            $display("FAIL outputs t=%0t: got we=%b sel=%b fl=%b to=%b sc=%0d, expected we=%b sel=%b fl=%b to=%b sc=%0d",
                     $time, got[24:21], got[20], got[19:17], got[16], got[15:0],
                     e[24:21], e[20], e[19:17], e[16], e[15:0]);
         end
      end
   end

   initial begin
      int budget;
      cyc(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1);
      cyc(0, 5, 5, 1, 1, 1, 5, 2'b01, 1, 1, 1, 0);
      idle(2);
      // load-use on rs
      cyc(1, 5, 0, 0, 1, 1, 5, 2'b00, 0, 0, 0, 1);
      idle(2);
      // r0 destination never stalls
      cyc(1, 0, 0, 1, 1, 1, 0, 2'b00, 0, 0, 0, 1);
      // load-use on rt only when rt is read
      cyc(1, 1, 7, 0, 1, 1, 7, 2'b00, 0, 0, 0, 1);
      cyc(1, 1, 7, 1, 1, 1, 7, 2'b00, 0, 0, 0, 1);
      // taken beq, then load-use while in FLUSH, then load-use in RUN
      cyc(1, 0, 0, 0, 0, 0, 0, 2'b01, 1, 0, 0, 1);
      cyc(1, 3, 0, 0, 1, 1, 3, 2'b00, 0, 0, 0, 1);
      cyc(1, 3, 0, 0, 1, 1, 3, 2'b00, 0, 0, 0, 1);
      cyc(1, 0, 0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 1);
      cyc(1, 0, 0, 0, 0, 0, 0, 2'b11, 1, 0, 0, 1);
      idle(1);
      // load waits three cycles
      repeat (3) cyc(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 1);
      idle(2);
      // memory never answers: timeout, sticky until reset
      repeat (20) cyc(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0, 0);
      idle(3);
      cyc(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1);
      idle(2);
      // all three hazards at once: stall first, branch on ready
      repeat (2) cyc(1, 4, 0, 0, 1, 1, 4, 2'b01, 1, 0, 1, 0);
      cyc(1, 4, 0, 0, 1, 1, 4, 2'b01, 1, 0, 1, 1);
      cyc(1, 4, 0, 0, 1, 1, 4, 2'b00, 0, 0, 0, 1);
      idle(2);
      // reset in the middle of a wait and a flush
      repeat (3) cyc(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0);
      cyc(1, 2, 0, 0, 1, 1, 2, 2'b00, 0, 0, 0, 1);
      cyc(1, 0, 0, 0, 0, 0, 0, 2'b01, 1, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1);
      cyc(1, 2, 0, 0, 1, 1, 2, 2'b00, 0, 0, 0, 1);
      idle(1);
      for (int i = 0; i < 4000; i++)
         cyc($urandom_range(0, 199) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)),
             2'($urandom), 1'($urandom), $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 9) < ((i / 500) % 2 == 0 ? 7 : 1));
      budget = 10;
      while (exp_q.size() > 0 && budget > 0) begin
         @(posedge clk);
         budget--;
      end
      if (exp_q.size() > 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: %0d expected responses left, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
